// File: rtl/led_stream_rx.sv
// led_stream_rx: decoder for the pulse-width coded status-LED stream.
// Recovers LED words with their frame position, frame ends and errors.
`timescale 1ns/1ps

module led_stream_rx #(
   parameter int WORD_BITS  = 24,
   parameter int NUM_LEDS   = 8,
   parameter int IDX_W      = 3,
   parameter int MIN_HIGH   = 8,
   parameter int BIT_THRESH = 24,
   parameter int MAX_HIGH   = 48,
   parameter int LATCH_LOW  = 2000,
   parameter int CNT_W      = 12
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 led_in,
   output logic [WORD_BITS-1:0] word_data,
   output logic                 word_valid,
   output logic [IDX_W-1:0]     word_index,
   output logic                 frame_done,
   output logic [IDX_W:0]       frame_words,
   output logic                 err_pulse,
   output logic                 err_sticky,
   input  logic                 err_clr
);

   localparam int BC_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

   localparam logic [CNT_W-1:0] C_LATCH  = CNT_W'(LATCH_LOW);
   localparam logic [CNT_W-1:0] C_MIN    = CNT_W'(MIN_HIGH);
   localparam logic [CNT_W-1:0] C_THRESH = CNT_W'(BIT_THRESH);
   localparam logic [CNT_W-1:0] C_MAX    = CNT_W'(MAX_HIGH);
   localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
   localparam logic [BC_W-1:0]  C_LAST   = BC_W'(WORD_BITS - 1);
   localparam logic [BC_W-1:0]  C_BC_ONE = BC_W'(1);
   localparam logic [IDX_W:0]   C_NUM    = (IDX_W + 1)'(NUM_LEDS);
   localparam logic [IDX_W:0]   C_WC_ONE = (IDX_W + 1)'(1);

   typedef enum logic [1:0] {
      ST_WAIT_LATCH,
      ST_IDLE,
      ST_HIGH,
      ST_LOW
   } state_t;

   state_t r_state;
   state_t w_next;

   logic r_sync1;
   logic r_sync2;
   logic r_sync3;

   logic [CNT_W-1:0]     r_cnt;
   logic [BC_W-1:0]      r_bit_cnt;
   logic [IDX_W:0]       r_word_cnt;
   logic [WORD_BITS-1:0] r_shift;
   logic                 r_ovf;

   logic w_s_in;
   logic w_rise;
   logic w_fall;
   logic w_latch;
   logic w_short;
   logic w_long;
   logic w_bit_val;

   logic                 w_start;
   logic                 w_shift;
   logic                 w_err_glitch;
   logic                 w_err_long;
   logic                 w_frame_end;
   logic                 w_word_end;
   logic                 w_word_ok;
   logic                 w_ovf;
   logic                 w_partial;
   logic                 w_done;
   logic                 w_err;
   logic [WORD_BITS-1:0] w_word_next;

   // Bring the asynchronous stream into the clock domain, plus one delay tap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= led_in;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_s_in = r_sync2;
   assign w_rise = r_sync2 & ~r_sync3;
   assign w_fall = ~r_sync2 & r_sync3;

   // Width of the current level; saturates so a long gap never wraps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (w_rise || w_fall) begin
         r_cnt <= C_ONE;
      end else if (r_cnt != C_LATCH) begin
         r_cnt <= r_cnt + C_ONE;
      end
   end

   // On a falling edge cnt still holds the high width just ended, so the
   // latch test must ignore that cycle.
   assign w_latch   = ~w_s_in & ~w_fall & (r_cnt == C_LATCH);
   assign w_short   = r_cnt < C_MIN;
   assign w_long    = w_s_in & (r_cnt == C_MAX);
   assign w_bit_val = r_cnt >= C_THRESH;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_WAIT_LATCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_WAIT_LATCH: begin
            if (w_latch) w_next = ST_IDLE;
         end
         ST_IDLE: begin
            if (w_rise) w_next = ST_HIGH;
         end
         ST_HIGH: begin
            if (w_fall) begin
               w_next = w_short ? ST_WAIT_LATCH : ST_LOW;
            end else if (w_long) begin
               w_next = ST_WAIT_LATCH;
            end
         end
         ST_LOW: begin
            if (w_rise) begin
               w_next = ST_HIGH;
            end else if (w_latch) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_WAIT_LATCH;
      endcase
   end

   // Per-state event strobes that steer the datapath and outputs.
   always_comb begin
      w_start      = 1'b0;
      w_shift      = 1'b0;
      w_err_glitch = 1'b0;
      w_err_long   = 1'b0;
      w_frame_end  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_start = w_rise;
         end
         ST_HIGH: begin
            if (w_fall) begin
               w_err_glitch = w_short;
               w_shift      = ~w_short;
            end else begin
               w_err_long = w_long;
            end
         end
         ST_LOW: begin
            w_frame_end = w_latch;
         end
         default: begin
            w_start = 1'b0;
         end
      endcase
   end

   assign w_word_end  = w_shift & (r_bit_cnt == C_LAST);
   assign w_word_ok   = w_word_end & (r_word_cnt < C_NUM);
   assign w_ovf       = w_word_end & (r_word_cnt == C_NUM) & ~r_ovf;
   assign w_partial   = w_frame_end & (r_bit_cnt != '0);
   assign w_done      = w_frame_end & (r_bit_cnt == '0) & (r_word_cnt != '0);
   assign w_err       = w_err_glitch | w_err_long | w_ovf | w_partial;
   assign w_word_next = {r_shift[WORD_BITS-2:0], w_bit_val};

   // Bit assembly and word bookkeeping within a frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_word_cnt <= '0;
         r_ovf      <= 1'b0;
      end else if (w_start) begin
         r_bit_cnt  <= '0;
         r_word_cnt <= '0;
         r_ovf      <= 1'b0;
      end else if (w_shift) begin
         r_shift <= w_word_next;
         if (w_word_end) begin
            r_bit_cnt <= '0;
         end else begin
            r_bit_cnt <= r_bit_cnt + C_BC_ONE;
         end
         if (w_word_ok) begin
            r_word_cnt <= r_word_cnt + C_WC_ONE;
         end
         if (w_ovf) begin
            r_ovf <= 1'b1;
         end
      end
   end

   // Word outputs; data and index hold until the next accepted word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_valid <= 1'b0;
         word_data  <= '0;
         word_index <= '0;
      end else begin
         word_valid <= w_word_ok;
         if (w_word_ok) begin
            word_data  <= w_word_next;
            word_index <= r_word_cnt[IDX_W-1:0];
         end
      end
   end

   // Frame outputs; the word count holds until the next completed frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_done  <= 1'b0;
         frame_words <= '0;
      end else begin
         frame_done <= w_done;
         if (w_done) begin
            frame_words <= r_word_cnt;
         end
      end
   end

   // Error strobe and sticky flag; a new error beats a clear request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_pulse  <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         err_pulse <= w_err;
         if (w_err) begin
            err_sticky <= 1'b1;
         end else if (err_clr) begin
            err_sticky <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_led_stream_rx.sv
// tb_led_stream_rx: directed + randomized bench for led_stream_rx.
// Expected events come from a pulse-level model of the stream rules.
`timescale 1ns/1ps

module tb_led_stream_rx;

   logic        clk;
   logic        reset_n;
   logic        led_in;
   logic        err_clr;
   logic [23:0] word_data;
   logic        word_valid;
   logic [2:0]  word_index;
   logic        frame_done;
   logic [3:0]  frame_words;
   logic        err_pulse;
   logic        err_sticky;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] aw[$];
   logic [31:0] ew[$];
   logic [31:0] ad[$];
   logic [31:0] ed[$];
   int aerr = 0;
   int last_err_cyc = 0;

   int          m_sync = 0;
   int          m_nbits = 0;
   int          m_words = 0;
   int          m_err = 0;
   int          m_fw = 0;
   logic [23:0] m_acc = '0;
   logic        m_sticky = 1'b0;

   led_stream_rx dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .led_in      (led_in),
      .word_data   (word_data),
      .word_valid  (word_valid),
      .word_index  (word_index),
      .frame_done  (frame_done),
      .frame_words (frame_words),
      .err_pulse   (err_pulse),
      .err_sticky  (err_sticky),
      .err_clr     (err_clr)
   );

   initial clk = 1'b0;
   always #12.5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record output events away from the active edge.
   always @(negedge clk) begin
      if (reset_n) begin
         if (word_valid) aw.push_back({5'd0, word_index, word_data});
         if (frame_done) ad.push_back({28'd0, frame_words});
         if (err_pulse) begin
            aerr <= aerr + 1;
            last_err_cyc <= cyc;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void m_error();
      m_err++;
      m_sticky = 1'b1;
   endfunction

   // One high pulse of h cycles.
   function automatic void m_high(input int h);
      if (m_sync == 0) return;
      if (h < 8 || h > 48) begin
         m_error();
         m_sync = 0;
         return;
      end
      m_acc = {m_acc[22:0], (h >= 24)};
      m_nbits++;
      if (m_nbits == 24) begin
         m_nbits = 0;
         if (m_words < 8) ew.push_back({5'd0, 3'(m_words), m_acc});
         else if (m_words == 8) m_error();
         m_words++;
      end
   endfunction

   // One low gap of l cycles; a gap longer than 2000 cycles is a latch.
   function automatic void m_low(input int l);
      if (l <= 2000) return;
      if (m_sync != 0) begin
         if (m_nbits != 0) begin
            m_error();
         end else if (m_words > 0) begin
            m_fw = (m_words > 8) ? 8 : m_words;
            ed.push_back(32'(m_fw));
         end
      end
      m_sync = 1;
      m_nbits = 0;
      m_words = 0;
   endfunction

   task automatic send(input int h, input int l);
      led_in = 1'b1;
      repeat (h) @(negedge clk);
      led_in = 1'b0;
      repeat (l) @(negedge clk);
      m_high(h);
      m_low(l);
   endtask

   task automatic gap(input int n);
      led_in = 1'b0;
      repeat (n) @(negedge clk);
      m_low(n);
   endtask

   task automatic send_bit(input logic b);
      int h;
      h = b ? int'($urandom_range(48, 24)) : int'($urandom_range(23, 8));
      send(h, int'($urandom_range(12, 2)));
   endtask

   task automatic send_word(input logic [23:0] d, input bit fixed);
      for (int i = 23; i >= 0; i--) begin
         if (fixed) send(d[i] ? 32 : 16, d[i] ? 18 : 34);
         else send_bit(d[i]);
      end
   endtask

   task automatic compare(input string tag);
      chk({tag, ".nwords"}, 32'(aw.size()), 32'(ew.size()));
      for (int i = 0; i < ew.size() && i < aw.size(); i++)
         chk({tag, ".word"}, aw[i], ew[i]);
      chk({tag, ".nframes"}, 32'(ad.size()), 32'(ed.size()));
      for (int i = 0; i < ed.size() && i < ad.size(); i++)
         chk({tag, ".fwords"}, ad[i], ed[i]);
      chk({tag, ".nerr"}, 32'(aerr), 32'(m_err));
      chk({tag, ".sticky"}, 32'(err_sticky), 32'(m_sticky));
      chk({tag, ".fw_hold"}, 32'(frame_words), 32'(m_fw));
      aw.delete();
      ew.delete();
      ad.delete();
      ed.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".wvalid"}, 32'(word_valid), 0);
      chk({tag, ".wdata"}, 32'(word_data), 0);
      chk({tag, ".widx"}, 32'(word_index), 0);
      chk({tag, ".fdone"}, 32'(frame_done), 0);
      chk({tag, ".fwords"}, 32'(frame_words), 0);
      chk({tag, ".epulse"}, 32'(err_pulse), 0);
      chk({tag, ".esticky"}, 32'(err_sticky), 0);
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      @(negedge clk);
      m_sticky = 1'b0;
   endtask

   initial begin
      int c0;
      int n;
      int pat[4];
      pat = '{23, 24, 8, 48};
      reset_n = 1'b0;
      led_in  = 1'b0;
      err_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      reset_n = 1'b1;
      gap(2100);

      send_word(24'hA5C30F, 1'b1);
      gap(2100);
      compare("one_word");

      for (int k = 1; k <= 8; k++) send_word(24'(k), 1'b0);
      gap(2100);
      compare("full_frame");

      for (int k = 0; k < 9; k++) send_word(24'($urandom), 1'b0);
      gap(2100);
      compare("overflow");
      clear_err();
      chk("err_clr", 32'(err_sticky), 32'(m_sticky));

      for (int i = 0; i < 5; i++) send_bit(1'($urandom));
      send(4, 10);
      for (int i = 0; i < 3; i++) send_bit(1'($urandom));
      gap(2100);
      send_word(24'($urandom), 1'b0);
      gap(2100);
      compare("glitch");

      c0 = cyc;
      send(60, 2100);
      chk("long_high.when", 32'(last_err_cyc - c0), 32'(2 + 48 + 1));
      compare("long_high");

      for (int i = 0; i < 24; i++)
         send(pat[i % 4], int'($urandom_range(12, 2)));
      gap(2100);
      compare("boundary");
      send(49, 2100);
      compare("high_49");

      for (int i = 0; i < 12; i++) send_bit(1'($urandom));
      gap(2100);
      compare("partial");

      repeat (2) begin
         n = int'($urandom_range(5, 1));
         for (int k = 0; k < n; k++) send_word(24'($urandom), 1'b0);
         gap(2100);
         compare("random");
      end

      send(60, 2100);
      compare("pre_reset");
      send_word(24'h5A5A5A, 1'b0);
      gap(2100);
      compare("pre_reset2");
      for (int i = 0; i < 10; i++) send_bit(1'($urandom));
      reset_n = 1'b0;
      #1;
      chk_zero("mid_reset");
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      m_sync = 0;
      m_nbits = 0;
      m_words = 0;
      m_sticky = 1'b0;
      m_fw = 0;
      send_word(24'($urandom), 1'b0);
      gap(2100);
      compare("rst_ignored");
      send_word(24'($urandom), 1'b0);
      gap(2100);
      compare("rst_resume");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
